// File: rtl/imm_issue_ctrl_pkg.sv
// Shared opcodes, immediate-mode and FSM encodings for the ID/EX immediate issue stage.
package imm_issue_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2,
    IMM_LUI  = 2'd3
  } imm_mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  function automatic imm_mode_e decode_mode(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ: decode_mode = IMM_SIGN;
      OP_ANDI, OP_ORI:                                 decode_mode = IMM_ZERO;
      OP_LUI:                                          decode_mode = IMM_LUI;
      default:                                         decode_mode = IMM_NONE;
    endcase
  endfunction

  // Opcodes whose rt field is a source operand (not a destination).
  function automatic logic reads_rt(input logic [5:0] op);
    reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/imm_issue_ctrl_imm_extender.sv
// Combinational immediate extender: sign, zero, upper-half (LUI) or none.
module imm_extender
  import imm_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_W-1:0]  imm,
  input  imm_mode_e         mode,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = '0;
    case (mode)
      IMM_SIGN: ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      IMM_ZERO: ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      IMM_LUI:  ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_issue_ctrl.sv
// ID/EX issue register for immediates with load-use bubble insertion.
module imm_issue_ctrl
  import imm_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic [DATA_W-1:0] ext_imm_out,
  output logic [1:0]        imm_mode_out,
  output logic [5:0]        opcode_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic              valid_out,
  output logic              hold_out
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ext_q, ext_d;
  imm_mode_e         mode_q, mode_d;
  logic [5:0]        op_q, op_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic              valid_q, valid_d;

  logic [5:0]        op_in;
  logic [4:0]        rs_in, rt_in;
  logic [IMM_W-1:0]  imm_in;
  imm_mode_e         mode_in;
  logic [DATA_W-1:0] ext_in;
  logic              hazard;

  assign op_in   = instr_in[31:26];
  assign rs_in   = instr_in[25:21];
  assign rt_in   = instr_in[20:16];
  assign imm_in  = instr_in[IMM_W-1:0];
  assign mode_in = decode_mode(op_in);

  imm_extender #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W)
  ) u_imm_extender (
    .imm (imm_in),
    .mode(mode_in),
    .ext (ext_in)
  );

  assign hazard = (state_q == ST_RUN) && valid_q && (op_q == OP_LW) && instr_valid &&
                  (rt_q != '0) && ((rt_q == rs_in) || (reads_rt(op_in) && (rt_q == rt_in)));

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    mode_d   = mode_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    valid_d  = valid_q;
    hold_out = 1'b0;
    if (!stall_in) begin
      // Every non-stalled edge defaults to loading a zeroed bubble in RUN.
      state_d = ST_RUN;
      ext_d   = '0;
      mode_d  = IMM_NONE;
      op_d    = '0;
      rs_d    = '0;
      rt_d    = '0;
      valid_d = 1'b0;
      if (flush_in) begin
        state_d = ST_RUN;
      end else if (hazard) begin
        state_d  = ST_BUBBLE;
        hold_out = !rst;
      end else if (instr_valid) begin
        ext_d   = ext_in;
        mode_d  = mode_in;
        op_d    = op_in;
        rs_d    = rs_in;
        rt_d    = rt_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ext_q   <= '0;
      mode_q  <= IMM_NONE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
    end
  end

  assign ext_imm_out  = ext_q;
  assign imm_mode_out = mode_q;
  assign opcode_out   = op_q;
  assign rs_out       = rs_q;
  assign rt_out       = rt_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Self-checking bench: directed literal cases plus randomized traffic against a behavioural model.
module tb_imm_issue_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] ext_imm_out;
  logic [1:0]  imm_mode_out;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic        valid_out;
  logic        hold_out;

  imm_issue_ctrl #(
    .DATA_W(32),
    .IMM_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .stall_in    (stall_in),
    .flush_in    (flush_in),
    .ext_imm_out (ext_imm_out),
    .imm_mode_out(imm_mode_out),
    .opcode_out  (opcode_out),
    .rs_out      (rs_out),
    .rt_out      (rt_out),
    .valid_out   (valid_out),
    .hold_out    (hold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Expected contents of the ID/EX slot.
  bit        m_valid;
  bit [5:0]  m_op;
  bit [4:0]  m_rs, m_rt;
  bit [31:0] m_ext;
  bit [1:0]  m_mode;
  bit        exp_hold;
  logic      obs_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit [1:0] ref_mode(input bit [5:0] op);
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04: return 2'd1;
      6'h0C, 6'h0D:                             return 2'd2;
      6'h0F:                                    return 2'd3;
      default:                                  return 2'd0;
    endcase
  endfunction

  function automatic bit [31:0] ref_ext(input bit [1:0] mode, input bit [15:0] imm);
    case (mode)
      2'd1:    return 32'($signed(imm));
      2'd2:    return 32'(imm);
      2'd3:    return 32'(imm) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                                     input bit [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_ext = 0; m_mode = 0;
  endtask

  // One clock: drive at the falling edge, check hold mid-cycle, check registers after the edge.
  task automatic cycle(input logic [31:0] ins, input bit v, input bit s, input bit f, input bit r);
    bit [5:0] op;
    bit [4:0] rs, rt;
    bool_uses_rt: begin end
    instr_in = ins; instr_valid = v; stall_in = s; flush_in = f; rst = r;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    #1;
    exp_hold = !r && !s && !f && v && m_valid && m_op == 6'h23 && m_rt != 0 &&
               (m_rt == rs || ((op == 6'h00 || op == 6'h2B || op == 6'h04) && m_rt == rt));
    obs_hold = hold_out;
    chk("hold_out", 32'(hold_out), 32'(exp_hold));
    if (r) model_clear();
    else if (s) begin end
    else if (f || exp_hold || !v) model_clear();
    else begin
      m_valid = 1; m_op = op; m_rs = rs; m_rt = rt;
      m_mode = ref_mode(op); m_ext = ref_ext(m_mode, ins[15:0]);
    end
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("ext_imm_out", ext_imm_out, m_ext);
    chk("imm_mode_out", 32'(imm_mode_out), 32'(m_mode));
    chk("opcode_out", 32'(opcode_out), 32'(m_op));
    chk("rs_out", 32'(rs_out), 32'(m_rs));
    chk("rt_out", 32'(rt_out), 32'(m_rt));
  endtask

  initial begin
    logic [31:0] cur;
    bit [5:0] ops [14];
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h23, 6'h23, 6'h2B, 6'h04,
            6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h23, 6'h3F};
    rst = 1; instr_in = 0; instr_valid = 0; stall_in = 0; flush_in = 0;
    model_clear();
    @(negedge clk);
    cycle(32'h0, 0, 1, 1, 1);
    cycle(mk(6'h08, 1, 2, 16'h1111), 1, 0, 0, 1);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_ext", ext_imm_out, 32'd0);

    cycle(mk(6'h08, 1, 2, 16'hFFF0), 1, 0, 0, 0);
    chk("addi_ext", ext_imm_out, 32'hFFFF_FFF0);
    chk("addi_mode", 32'(imm_mode_out), 32'd1);
    chk("addi_valid", 32'(valid_out), 32'd1);
    cycle(mk(6'h0D, 1, 2, 16'h8001), 1, 0, 0, 0);
    chk("ori_ext", ext_imm_out, 32'h0000_8001);
    cycle(mk(6'h0F, 0, 4, 16'h1234), 1, 0, 0, 0);
    chk("lui_ext", ext_imm_out, 32'h1234_0000);
    chk("lui_mode", 32'(imm_mode_out), 32'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(mk(6'h08, 1, 2, 16'h0007), 1, 1, i == 1, 0);
      chk("stall_ext", ext_imm_out, 32'h1234_0000);
      chk("stall_hold", 32'(obs_hold), 32'd0);
    end

    cycle(mk(6'h23, 0, 8, 16'h0004), 1, 0, 0, 0);
    cycle(mk(6'h00, 8, 9, 16'h0000), 1, 0, 0, 0);
    chk("lu_hold", 32'(obs_hold), 32'd1);
    chk("lu_bubble", 32'(valid_out), 32'd0);
    cycle(mk(6'h00, 8, 9, 16'h0000), 1, 0, 0, 0);
    chk("lu_hold_after", 32'(obs_hold), 32'd0);
    chk("lu_issue", 32'(valid_out), 32'd1);
    chk("lu_issue_rs", 32'(rs_out), 32'd8);

    cycle(mk(6'h23, 0, 0, 16'h0000), 1, 0, 0, 0);
    cycle(mk(6'h00, 0, 0, 16'h0000), 1, 0, 0, 0);
    chk("zero_reg_hold", 32'(obs_hold), 32'd0);
    chk("zero_reg_valid", 32'(valid_out), 32'd1);

    cycle(mk(6'h23, 0, 5, 16'h0000), 1, 0, 0, 0);
    cycle(mk(6'h00, 5, 1, 16'h0000), 1, 0, 1, 0);
    chk("flush_hold", 32'(obs_hold), 32'd0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    cycle(mk(6'h00, 5, 1, 16'h0000), 1, 0, 0, 0);
    chk("flush_next_hold", 32'(obs_hold), 32'd0);
    chk("flush_next_valid", 32'(valid_out), 32'd1);

    cycle(mk(6'h23, 0, 3, 16'h0000), 1, 0, 0, 0);
    cycle(mk(6'h2B, 1, 3, 16'h0010), 1, 0, 0, 0);
    chk("sw_rt_hold", 32'(obs_hold), 32'd1);
    cycle(mk(6'h2B, 1, 3, 16'h0010), 1, 0, 0, 1);
    chk("rst_bub_valid", 32'(valid_out), 32'd0);
    chk("rst_bub_hold", 32'(obs_hold), 32'd0);
    chk("rst_bub_op", 32'(opcode_out), 32'd0);
    cycle(mk(6'h2B, 1, 3, 16'h0010), 1, 0, 0, 0);
    chk("rst_bub_issue", 32'(valid_out), 32'd1);
    chk("rst_bub_ext", ext_imm_out, 32'h0000_0010);
    cycle(mk(6'h08, 1, 1, 16'h0001), 0, 0, 0, 0);
    chk("invalid_valid", 32'(valid_out), 32'd0);

    // Randomized traffic; IF/ID re-presents the instruction whenever the model expects a hold.
    cur = mk(6'h23, 0, 1, 16'h0);
    for (int unsigned i = 0; i < 600; i++) begin
      if (!exp_hold)
        cur = mk(ops[$urandom_range(13)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                 16'($urandom));
      cycle(cur, $urandom_range(7) != 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
            $urandom_range(63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
